muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [3:0] {
        OP_MUL    = 4'b1000,
        OP_DIV    = 4'b1001,
        OP_DIVU   = 4'b1010,
        OP_REM    = 4'b1011,
        OP_REMU   = 4'b1100,
        OP_MULH   = 4'b1101,
        OP_MULHSU = 4'b1110,
        OP_MULHU  = 4'b1111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
module muldiv_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    import muldiv_pkg::*;

    md_state_e         state;
    logic [2*XLEN-1:0] acc;       // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
    logic [4:0]        count;
    logic              div_q;
    logic              rem_q;
    logic              mul_lo_q;
    logic              neg_q;     // negate product / quotient
    logic              neg_r;     // negate remainder

    // Request decode: operand signedness, magnitudes and special-case detection
    md_op_e          op_in;
    logic            div_in, signed_a, signed_b, sa, sb, b_zero, ovf, fast_take;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign op_in = md_op_e'(op);

    always_comb begin
        div_in    = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        signed_a  = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        signed_b  = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa        = signed_a & rs1[XLEN-1];
        sb        = signed_b & rs2[XLEN-1];
        mag_a     = sa ? -rs1 : rs1;
        mag_b     = sb ? -rs2 : rs2;
        b_zero    = (rs2 == '0);
        ovf       = (op_in == OP_DIV || op_in == OP_REM) &&
                    (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        fast_take = FAST_SPECIAL && div_in && (b_zero || ovf);
        // x/0: quotient all ones, remainder rs1; overflow: quotient rs1 (0x8000_0000), remainder 0
        if (b_zero)
            special_res = (op_in == OP_DIV || op_in == OP_DIVU) ? DIV_ZERO_Q : rs1;
        else
            special_res = (op_in == OP_DIV) ? rs1 : '0;
    end

    // One iteration through the shared adder/subtractor, plus sign fix-up of its output
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   add_a, add_b, add_sum;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quot, remv, fix_res;

    always_comb begin
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        add_a   = div_q ? {1'b0, rem_sh} : {2'b00, acc[2*XLEN-1:XLEN]};
        add_b   = div_q ? ~{2'b00, opnd} : (acc[0] ? {2'b00, opnd} : '0);
        add_sum = add_a + add_b + {{(XLEN+1){1'b0}}, div_q};
        if (div_q) begin
            // restoring step: keep the difference only when it did not go negative
            if (!add_sum[XLEN+1])
                acc_next = {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            // shift-add: carry out of the high half shifts into bit 63
            acc_next = {add_sum[XLEN:0], acc[XLEN-1:1]};
        end
        prod    = neg_q ? -acc_next : acc_next;
        quot    = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        remv    = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (div_q)
            fix_res = rem_q ? remv : quot;
        else
            fix_res = mul_lo_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            opnd     <= '0;
            count    <= '0;
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            mul_lo_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !kill) begin
                        count    <= '0;
                        div_q    <= div_in;
                        rem_q    <= (op_in == OP_REM || op_in == OP_REMU);
                        mul_lo_q <= (op_in == OP_MUL);
                        // divide by zero keeps the all-ones quotient unsigned
                        neg_q    <= (sa ^ sb) & ~(div_in & b_zero);
                        neg_r    <= sa;
                        acc      <= div_in ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        opnd     <= div_in ? mag_b : mag_a;
                        if (!op[3]) begin
                            result <= '0;
                            state  <= DONE;
                        end else if (fast_take) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            result <= fix_res;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (kill || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (fast and iterative special handling)
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid [2];
    logic        kill     [2];
    logic        out_ready[2];
    logic [3:0]  op       [2];
    logic [31:0] rs1      [2];
    logic [31:0] rs2      [2];
    logic        in_ready [2];
    logic        out_valid[2];
    logic        busy     [2];
    logic [31:0] result   [2];

    int tests;
    int fails;
    bit chk_en;

    // reference model state per instance
    bit          m_pend[2];
    int          m_age [2];
    int          m_lat [2];
    logic [31:0] m_res [2];

    muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .rs1(rs1[0]), .rs2(rs2[0]), .kill(kill[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
    );

    muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .rs1(rs1[1]), .rs2(rs2[1]), .kill(kill[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int s, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d got=%h expected=%h at %0t", nm, s, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        u;
        case (o)
            OP_MUL:    begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0];  end
            OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});       return p[63:32]; end
            OP_MULHU:  begin u = {32'h0, a} * {32'h0, b};                               return u[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // edges from acceptance until out_valid is sampled high
    function automatic int exp_lat(input bit fast, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[3]) return 1;
        if (fast && (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) &&
            (b == 0 || ((o == OP_DIV || o == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    // model: track an outstanding request per instance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pend[i] = 1'b0;
            end else if (m_pend[i]) begin
                if (kill[i]) m_pend[i] = 1'b0;
                else if (m_age[i] >= m_lat[i] - 1 && out_ready[i]) m_pend[i] = 1'b0;
                else m_age[i]++;
            end else if (in_valid[i] && !kill[i]) begin
                m_pend[i] = 1'b1;
                m_age[i]  = 0;
                m_lat[i]  = exp_lat(i == 0, op[i], rs1[i], rs2[i]);
                m_res[i]  = ref_model(op[i], rs1[i], rs2[i]);
            end
        end
    end

    // compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit ev;
                ev = m_pend[i] && (m_age[i] >= m_lat[i] - 1);
                check("cyc_in_ready", i, 32'(in_ready[i]), 32'(!m_pend[i]));
                check("cyc_busy", i, 32'(busy[i]), 32'(m_pend[i]));
                check("cyc_out_valid", i, 32'(out_valid[i]), 32'(ev));
                if (ev) check("cyc_result", i, result[i], m_res[i]);
            end
        end
    end

    // issue one op, scramble inputs after acceptance, measure latency, handshake
    task automatic do_op(input int s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int lat, input string nm);
        int n;
        check({nm, "_model"}, s, ref_model(o, a, b), lit);
        in_valid[s] = 1'b1; op[s] = o; rs1[s] = a; rs2[s] = b;
        @(posedge clk);
        @(negedge clk);
        in_valid[s] = 1'b0; rs1[s] = $urandom; rs2[s] = $urandom; op[s] = 4'($urandom);
        n = 1;
        while (!out_valid[s] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_lat"}, s, 32'(n), 32'(lat));
        check({nm, "_res"}, s, result[s], lit);
        out_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[s] = 1'b0;
        check({nm, "_ready_after"}, s, 32'(in_ready[s]), 32'd1);
    endtask

    task automatic run_vectors(input int s);
        int sl;
        sl = (s == 0) ? 1 : 33;
        do_op(s, OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
        do_op(s, OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33, "mulh");
        do_op(s, OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        do_op(s, OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
        do_op(s, OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33, "div");
        do_op(s, OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33, "rem");
        do_op(s, OP_DIVU,   32'd100,        32'd7,        32'd14,       33, "divu");
        do_op(s, OP_REMU,   32'd100,        32'd7,        32'd2,        33, "remu");
        do_op(s, OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, sl, "div_by0");
        do_op(s, OP_REMU,   32'd5,          32'd0,        32'd5,        sl, "remu_by0");
        do_op(s, OP_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, sl, "rem_neg_by0");
        do_op(s, OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, sl, "div_ovf");
        do_op(s, OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h0,        sl, "rem_ovf");
        do_op(s, 4'b0011,   32'd9,          32'd9,        32'h0,        1,  "non_m_op");
    endtask

    initial begin
        int n;
        tests = 0; fails = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; kill[i] = 1'b0; out_ready[i] = 1'b0;
            op[i] = 4'h0; rs1[i] = 32'h0; rs2[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
            check("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
            check("rst_busy", i, 32'(busy[i]), 32'd0);
            check("rst_result", i, result[i], 32'h0);
        end
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_vectors(0);
        run_vectors(1);

        // backpressure: result and handshake held for 10 cycles
        in_valid[0] = 1'b1; op[0] = OP_DIVU; rs1[0] = 32'd100; rs2[0] = 32'd7;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        n = 1;
        while (!out_valid[0] && n < 60) begin @(negedge clk); n++; end
        check("bp_lat", 0, 32'(n), 32'd33);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", 0, 32'(out_valid[0]), 32'd1);
            check("bp_result", 0, result[0], 32'd14);
            check("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_ready_after", 0, 32'(in_ready[0]), 32'd1);
        do_op(0, OP_REMU, 32'd100, 32'd7, 32'd2, 33, "bp_second");

        // kill with in_valid in IDLE: not accepted
        in_valid[0] = 1'b1; kill[0] = 1'b1; op[0] = OP_MUL; rs1[0] = 32'd2; rs2[0] = 32'd2;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0; kill[0] = 1'b0;
        check("kill_idle_ready", 0, 32'(in_ready[0]), 32'd1);
        check("kill_idle_busy", 0, 32'(busy[0]), 32'd0);

        // kill at count=15
        in_valid[0] = 1'b1; op[0] = OP_MUL; rs1[0] = 32'h12345678; rs2[0] = 32'd9;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (15) @(negedge clk);
        kill[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        kill[0] = 1'b0;
        check("kill_calc_ready", 0, 32'(in_ready[0]), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (out_valid[0]) n++; end
        check("kill_no_valid", 0, 32'(n), 32'd0);
        do_op(0, OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul_after_kill");

        // kill in DONE
        in_valid[0] = 1'b1; op[0] = OP_DIV; rs1[0] = 32'd5; rs2[0] = 32'd0;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        check("kdone_valid", 0, 32'(out_valid[0]), 32'd1);
        kill[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        kill[0] = 1'b0; out_ready[0] = 1'b0;
        check("kdone_out_valid", 0, 32'(out_valid[0]), 32'd0);
        check("kdone_ready", 0, 32'(in_ready[0]), 32'd1);

        // reset during CALC
        in_valid[1] = 1'b1; op[1] = OP_MULHU; rs1[1] = 32'hDEADBEEF; rs2[1] = 32'h12345;
        @(posedge clk); @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rcalc_in_ready", 1, 32'(in_ready[1]), 32'd1);
        check("rcalc_out_valid", 1, 32'(out_valid[1]), 32'd0);
        check("rcalc_busy", 1, 32'(busy[1]), 32'd0);
        check("rcalc_result", 1, result[1], 32'h0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (out_valid[1]) n++; end
        check("rcalc_no_valid", 1, 32'(n), 32'd0);
        do_op(1, OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
